wb_stage_pipe: RTL and testbench

//  Registered, parametrised writeback stage. Captures MEM-stage results into a MEM/WB register.

---
 rtl/rv_pkg.sv | 30 +++
 rtl/wb_stage_pipe_if.sv | 29 ++
 rtl/wb_load_align.sv | 28 ++
 rtl/wb_stage_pipe.sv | 137 +++++++++++++
 tb/tb_wb_stage_pipe.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V pipeline definitions: load funct3 encodings and the retired-write history entry.
package rv_pkg;

    localparam int unsigned RV_XLEN = 32;
    localparam int unsigned REG_AW  = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic               v;
        logic [REG_AW-1:0]  rd;
        logic [RV_XLEN-1:0] data;
    } wb_entry_t;

    // Reserved encodings behave as LW, including the alignment rule.
    function automatic logic load_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3)
            F3_LB, F3_LBU: mis = 1'b0;
            F3_LH, F3_LHU: mis = addr_lo[0];
            default:       mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/wb_stage_pipe_if.sv
// MEM -> WB transfer bus with valid/ready handshake.
interface wb_stage_pipe_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   alu_result_mem;
    logic [WORD_W-1:0] load_word_mem;
    logic [1:0]        addr_lo_mem;
    logic [2:0]        funct3_mem;
    logic [REG_W-1:0]  rd_mem;
    logic              reg_write_mem;
    logic              memtoreg_mem;

    modport master (
        output in_valid, alu_result_mem, load_word_mem, addr_lo_mem,
               funct3_mem, rd_mem, reg_write_mem, memtoreg_mem,
        input  in_ready
    );

    modport slave (
        input  in_valid, alu_result_mem, load_word_mem, addr_lo_mem,
               funct3_mem, rd_mem, reg_write_mem, memtoreg_mem,
        output in_ready
    );
endinterface

// File: rtl/wb_load_align.sv
// Combinational load formatter: selects byte/half/word from an aligned word and flags misalignment.
module wb_load_align
    import rv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(word >> {addr_lo, 3'b000});
        half_sel = 16'(word >> {addr_lo[1], 4'b0000});
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'd0, half_sel};
            default: data = word;
        endcase
        misalign = load_misaligned(funct3, addr_lo);
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// Writeback stage: MEM/WB register, load formatting, regfile write port,
// retired-write history for decode bypass and retired-instruction counter.
module wb_stage_pipe
    import rv_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned BYPASS_DEPTH = 2,
    parameter int unsigned CNT_W        = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wb_stage_pipe_if.slave       mem,
    input  logic                 flush_wb,
    input  logic                 wb_hold,
    output logic [XLEN-1:0]      wb_write_data,
    output logic [REG_AW-1:0]    wb_write_addr,
    output logic                 wb_write_en,
    output logic                 wb_valid,
    output logic                 misalign_err,
    input  logic [REG_AW-1:0]    rs1_addr,
    input  logic [REG_AW-1:0]    rs2_addr,
    output logic                 rs1_hit,
    output logic [XLEN-1:0]      rs1_data,
    output logic                 rs2_hit,
    output logic [XLEN-1:0]      rs2_data,
    output logic [CNT_W-1:0]     instret_count
);

    localparam int unsigned WORD_W = 32;

    logic [XLEN-1:0]   wb_alu;
    logic [WORD_W-1:0] wb_word;
    logic [1:0]        wb_addr_lo;
    logic [2:0]        wb_funct3;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_reg_write;
    logic              wb_memtoreg;

    logic [WORD_W-1:0] load_data;
    logic              load_misalign;
    logic              commit;

    wb_entry_t hist [BYPASS_DEPTH];

    assign mem.in_ready = !wb_hold;

    // MEM/WB register; flush kills the held instruction even while frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid     <= 1'b0;
            wb_alu       <= '0;
            wb_word      <= '0;
            wb_addr_lo   <= '0;
            wb_funct3    <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            wb_memtoreg  <= 1'b0;
        end else if (!wb_hold) begin
            wb_valid     <= mem.in_valid & !flush_wb;
            wb_alu       <= mem.alu_result_mem;
            wb_word      <= mem.load_word_mem;
            wb_addr_lo   <= mem.addr_lo_mem;
            wb_funct3    <= mem.funct3_mem;
            wb_rd        <= mem.rd_mem;
            wb_reg_write <= mem.reg_write_mem;
            wb_memtoreg  <= mem.memtoreg_mem;
        end else if (flush_wb) begin
            wb_valid     <= 1'b0;
        end
    end

    wb_load_align u_load_align (
        .word     (wb_word),
        .addr_lo  (wb_addr_lo),
        .funct3   (wb_funct3),
        .data     (load_data),
        .misalign (load_misalign)
    );

    // Commit-cycle decode of the regfile write port.
    always_comb begin
        commit        = wb_valid & !wb_hold;
        misalign_err  = commit & wb_memtoreg & load_misalign;
        wb_write_en   = commit & wb_reg_write & (wb_rd != '0) & !misalign_err;
        wb_write_addr = wb_rd;
        wb_write_data = wb_memtoreg ? XLEN'(load_data) : wb_alu;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_count <= '0;
        end else if (commit) begin
            instret_count <= instret_count + CNT_W'(1);
        end
    end

    // Retired-write history; entry 0 is the youngest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BYPASS_DEPTH); i++) begin
                hist[i] <= '0;
            end
        end else if (wb_write_en) begin
            hist[0] <= '{v: 1'b1, rd: wb_rd, data: RV_XLEN'(wb_write_data)};
            for (int i = 1; i < int'(BYPASS_DEPTH); i++) begin
                hist[i] <= hist[i-1];
            end
        end
    end

    // Bypass search from oldest to youngest so younger matches overwrite; live write wins.
    always_comb begin
        rs1_hit  = 1'b0;
        rs1_data = '0;
        rs2_hit  = 1'b0;
        rs2_data = '0;
        for (int i = int'(BYPASS_DEPTH) - 1; i >= 0; i--) begin
            if (hist[i].v && (rs1_addr != '0) && (hist[i].rd == rs1_addr)) begin
                rs1_hit  = 1'b1;
                rs1_data = XLEN'(hist[i].data);
            end
            if (hist[i].v && (rs2_addr != '0) && (hist[i].rd == rs2_addr)) begin
                rs2_hit  = 1'b1;
                rs2_data = XLEN'(hist[i].data);
            end
        end
        if (wb_write_en && (rs1_addr != '0) && (wb_write_addr == rs1_addr)) begin
            rs1_hit  = 1'b1;
            rs1_data = wb_write_data;
        end
        if (wb_write_en && (rs2_addr != '0) && (wb_write_addr == rs2_addr)) begin
            rs2_hit  = 1'b1;
            rs2_data = wb_write_data;
        end
    end

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe with a write-port scoreboard.
module tb_wb_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_wb;
    logic        wb_hold;
    logic [31:0] wb_write_data;
    logic [4:0]  wb_write_addr;
    logic        wb_write_en;
    logic        wb_valid;
    logic        misalign_err;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_hit;
    logic [31:0] rs1_data;
    logic        rs2_hit;
    logic [31:0] rs2_data;
    logic [63:0] instret_count;

    always #5 clk = ~clk;

    wb_stage_pipe_if #(.XLEN(32)) mem_if ();

    wb_stage_pipe #(.XLEN(32), .BYPASS_DEPTH(2), .CNT_W(64)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem           (mem_if.slave),
        .flush_wb      (flush_wb),
        .wb_hold       (wb_hold),
        .wb_write_data (wb_write_data),
        .wb_write_addr (wb_write_addr),
        .wb_write_en   (wb_write_en),
        .wb_valid      (wb_valid),
        .misalign_err  (misalign_err),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_hit       (rs1_hit),
        .rs1_data      (rs1_data),
        .rs2_hit       (rs2_hit),
        .rs2_data      (rs2_data),
        .instret_count (instret_count)
    );

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] exp_cnt;

    localparam logic [31:0] WORD = 32'h80F1_7F82;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] addr, input logic [31:0] data);
        exp_t e;
        e.addr = addr;
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Presents one instruction for a single cycle; returns 1ns after the capturing edge.
    task automatic drive(input logic [4:0] rd, input logic rw, input logic m2r,
                         input logic [31:0] alu, input logic [1:0] off, input logic [2:0] f3);
        mem_if.in_valid       = 1'b1;
        mem_if.rd_mem         = rd;
        mem_if.reg_write_mem  = rw;
        mem_if.memtoreg_mem   = m2r;
        mem_if.alu_result_mem = alu;
        mem_if.load_word_mem  = WORD;
        mem_if.addr_lo_mem    = off;
        mem_if.funct3_mem     = f3;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every regfile write must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && wb_write_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_write", 64'(wb_write_en), 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("wr_addr", 64'(wb_write_addr), 64'(e.addr));
                chk("wr_data", 64'(wb_write_data), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n                 = 1'b0;
        flush_wb              = 1'b0;
        wb_hold               = 1'b0;
        rs1_addr              = 5'd0;
        rs2_addr              = 5'd0;
        mem_if.in_valid       = 1'b0;
        mem_if.rd_mem         = 5'd0;
        mem_if.reg_write_mem  = 1'b0;
        mem_if.memtoreg_mem   = 1'b0;
        mem_if.alu_result_mem = 32'd0;
        mem_if.load_word_mem  = 32'd0;
        mem_if.addr_lo_mem    = 2'd0;
        mem_if.funct3_mem     = 3'd0;
        exp_cnt               = 64'd0;
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;

        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_write_en", 64'(wb_write_en), 64'd0);
        chk("rst_misalign", 64'(misalign_err), 64'd0);
        chk("rst_instret", instret_count, 64'd0);
        chk("rst_rs1_hit", 64'(rs1_hit), 64'd0);
        chk("rst_in_ready", 64'(mem_if.in_ready), 64'd1);

        // Load formatting
        expect_wr(5'd10, 32'hFFFF_FF82); exp_cnt++; drive(5'd10, 1'b1, 1'b1, 32'hDEAD_BEEF, 2'd0, 3'b000);
        chk("lb_valid", 64'(wb_valid), 64'd1);
        expect_wr(5'd11, 32'h0000_007F); exp_cnt++; drive(5'd11, 1'b1, 1'b1, 32'hDEAD_BEEF, 2'd1, 3'b100);
        expect_wr(5'd12, 32'hFFFF_80F1); exp_cnt++; drive(5'd12, 1'b1, 1'b1, 32'hDEAD_BEEF, 2'd2, 3'b001);
        expect_wr(5'd13, 32'h80F1_7F82); exp_cnt++; drive(5'd13, 1'b1, 1'b1, 32'hDEAD_BEEF, 2'd0, 3'b010);
        idle();
        chk("instret_loads", instret_count, exp_cnt);

        // Misaligned LW: no write, still retires
        exp_cnt++; drive(5'd5, 1'b1, 1'b1, 32'h0, 2'd1, 3'b010);
        chk("mis_err", 64'(misalign_err), 64'd1);
        chk("mis_write_en", 64'(wb_write_en), 64'd0);
        idle();
        chk("mis_err_clear", 64'(misalign_err), 64'd0);
        chk("instret_mis", instret_count, exp_cnt);

        // ALU result ignores load alignment
        expect_wr(5'd6, 32'h0000_0055); exp_cnt++; drive(5'd6, 1'b1, 1'b0, 32'h55, 2'd1, 3'b010);
        chk("alu_no_mis", 64'(misalign_err), 64'd0);
        idle();

        // Hold for three cycles on ADD x7
        expect_wr(5'd7, 32'h0000_1234); exp_cnt++; drive(5'd7, 1'b1, 1'b0, 32'h1234, 2'd0, 3'b000);
        mem_if.in_valid = 1'b0;
        wb_hold = 1'b1;
        #1;
        chk("hold_write_en", 64'(wb_write_en), 64'd0);
        chk("hold_in_ready", 64'(mem_if.in_ready), 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("hold_write_en", 64'(wb_write_en), 64'd0);
            chk("hold_wb_valid", 64'(wb_valid), 64'd1);
        end
        wb_hold = 1'b0;
        #1;
        chk("release_write_en", 64'(wb_write_en), 64'd1);
        chk("instret_during_hold", instret_count, exp_cnt - 64'd1);
        @(posedge clk);
        #1;
        chk("instret_hold", instret_count, exp_cnt);
        chk("hold_drained", 64'(wb_valid), 64'd0);

        // Flush during hold
        drive(5'd8, 1'b1, 1'b0, 32'h88, 2'd0, 3'b000);
        mem_if.in_valid = 1'b0;
        wb_hold  = 1'b1;
        flush_wb = 1'b1;
        #1;
        chk("flush_write_en", 64'(wb_write_en), 64'd0);
        @(posedge clk);
        #1;
        flush_wb = 1'b0;
        chk("flush_wb_valid", 64'(wb_valid), 64'd0);
        wb_hold = 1'b0;
        #1;
        chk("flush_no_write", 64'(wb_write_en), 64'd0);
        idle();
        chk("instret_flush", instret_count, exp_cnt);

        // Writes to x0 are dropped and x0 never bypasses
        exp_cnt++; drive(5'd0, 1'b1, 1'b0, 32'h77, 2'd0, 3'b000);
        rs1_addr = 5'd0;
        #1;
        chk("x0_write_en", 64'(wb_write_en), 64'd0);
        chk("x0_rs1_hit", 64'(rs1_hit), 64'd0);
        idle();

        // Bypass priority and ageing
        expect_wr(5'd3, 32'd1); exp_cnt++; drive(5'd3, 1'b1, 1'b0, 32'd1, 2'd0, 3'b000);
        expect_wr(5'd3, 32'd2); exp_cnt++; drive(5'd3, 1'b1, 1'b0, 32'd2, 2'd0, 3'b000);
        expect_wr(5'd4, 32'd9); exp_cnt++; drive(5'd4, 1'b1, 1'b0, 32'd9, 2'd0, 3'b000);
        mem_if.in_valid = 1'b0;
        rs1_addr = 5'd3;
        rs2_addr = 5'd4;
        #1;
        chk("byp_rs1_hit", 64'(rs1_hit), 64'd1);
        chk("byp_rs1_data", 64'(rs1_data), 64'd2);
        chk("byp_rs2_hit", 64'(rs2_hit), 64'd1);
        chk("byp_rs2_data", 64'(rs2_data), 64'd9);
        idle();
        chk("hist_rs1_data", 64'(rs1_data), 64'd2);
        chk("hist_rs2_data", 64'(rs2_data), 64'd9);
        expect_wr(5'd5, 32'h50); exp_cnt++; drive(5'd5, 1'b1, 1'b0, 32'h50, 2'd0, 3'b000);
        expect_wr(5'd6, 32'h60); exp_cnt++; drive(5'd6, 1'b1, 1'b0, 32'h60, 2'd0, 3'b000);
        mem_if.in_valid = 1'b0;
        #1;
        chk("aged_rs1_hit", 64'(rs1_hit), 64'd0);
        chk("aged_rs1_data", 64'(rs1_data), 64'd0);
        idle();
        chk("aged_rs1_hit2", 64'(rs1_hit), 64'd0);
        chk("instret_byp", instret_count, exp_cnt);

        // Asynchronous reset with a commit in flight
        drive(5'd9, 1'b1, 1'b0, 32'h99, 2'd0, 3'b000);
        mem_if.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_write_en", 64'(wb_write_en), 64'd0);
        chk("arst_wb_valid", 64'(wb_valid), 64'd0);
        chk("arst_instret", instret_count, 64'd0);
        chk("arst_rs2_hit", 64'(rs2_hit), 64'd0);
        chk("arst_rs2_data", 64'(rs2_data), 64'd0);
        exp_cnt = 64'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_wr(5'd4, 32'hAB); exp_cnt++; drive(5'd4, 1'b1, 1'b0, 32'hAB, 2'd0, 3'b000);
        idle();
        chk("instret_post_rst", instret_count, exp_cnt);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
